sync_fifo: RTL

//  Single-clock, parametrised FIFO for buffering operand/result words between pipeline stages

---
 rtl/sync_fifo.sv | 133 +++++++++++++
 1 files changed

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO that buffers operand/result words between pipeline
//   stages of the multiply/divide datapath. It supports a normal or show-ahead
//   read mode, any depth from 2 to 2**ADDR_LEN, a fill-level count,
//   programmable almost-full/almost-empty thresholds, and sticky
//   overflow/underflow error flags.
//
// Parameters
//   DATA_LEN        word width in bits
//   ADDR_LEN        pointer width; FIFO_DEPTH <= 2**ADDR_LEN
//   FIFO_DEPTH      number of storage words (>= 2, any value)
//   SHOWAHEAD       0: data_out updates one cycle after an accepted rd_en
//                   1: the head word is presented while not empty; rd_en pops it
//   ALMOST_FULL_TH  almost_full  when usedw >= this value
//   ALMOST_EMPTY_TH almost_empty when usedw <= this value
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-high
//   data_in       in   write data
//   wrt_en        in   write request
//   wrt_full      out  usedw == FIFO_DEPTH
//   rd_en         in   read request (pop of the head word in show-ahead mode)
//   data_out      out  read data
//   rd_empty      out  usedw == 0
//   usedw         out  number of stored words, 0..FIFO_DEPTH
//   almost_full   out  usedw >= ALMOST_FULL_TH
//   almost_empty  out  usedw <= ALMOST_EMPTY_TH
//   overflow      out  sticky: a write was attempted while full
//   underflow     out  sticky: a read was attempted while empty
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter int DATA_LEN        = 16,
   parameter int ADDR_LEN        = 4,
   parameter int FIFO_DEPTH      = 1 << ADDR_LEN,
   parameter bit SHOWAHEAD       = 1'b0,
   parameter int ALMOST_FULL_TH  = FIFO_DEPTH - 2,
   parameter int ALMOST_EMPTY_TH = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [DATA_LEN-1:0] data_in,
   input  logic                wrt_en,
   output logic                wrt_full,
   input  logic                rd_en,
   output logic [DATA_LEN-1:0] data_out,
   output logic                rd_empty,
   output logic [ADDR_LEN:0]   usedw,
   output logic                almost_full,
   output logic                almost_empty,
   output logic                overflow,
   output logic                underflow
);

   localparam int CNT_W = ADDR_LEN + 1;

   localparam logic [CNT_W-1:0]    DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0]    AF_C    = CNT_W'(ALMOST_FULL_TH);
   localparam logic [CNT_W-1:0]    AE_C    = CNT_W'(ALMOST_EMPTY_TH);
   localparam logic [ADDR_LEN-1:0] LAST_C  = ADDR_LEN'(FIFO_DEPTH - 1);

   logic [DATA_LEN-1:0] mem [FIFO_DEPTH];
   logic [ADDR_LEN-1:0] wr_ptr;
   logic [ADDR_LEN-1:0] rd_ptr;
   logic [CNT_W-1:0]    count_next;
   logic                wr_ok;
   logic                rd_ok;

   // Wrap explicitly at FIFO_DEPTH-1 so that depths which are not a power of two work.
   function automatic logic [ADDR_LEN-1:0] next_ptr(input logic [ADDR_LEN-1:0] p);
      return (p == LAST_C) ? '0 : p + ADDR_LEN'(1);
   endfunction

   // Accept decisions use the registered flags. A write while full is dropped
   // even when a read is accepted in the same cycle.
   assign wr_ok      = wrt_en & ~wrt_full;
   assign rd_ok      = rd_en  & ~rd_empty;
   assign count_next = usedw + CNT_W'(wr_ok) - CNT_W'(rd_ok);

   // NOTE: storage has no reset. Its contents are meaningless until written,
   // and leaving it unreset lets it map onto plain RAM/register-file cells.
   always_ff @(posedge clk) begin
      if (wr_ok && !reset)
         mem[wr_ptr] <= data_in;
   end

   // NOTE: all state is updated with non-blocking assignments so that every
   // flag below is computed from the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         usedw        <= '0;
         wrt_full     <= 1'b0;
         rd_empty     <= 1'b1;
         almost_full  <= (AF_C == '0);
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= next_ptr(wr_ptr);
         if (rd_ok) rd_ptr <= next_ptr(rd_ptr);
         // Status flags are registered from the post-edge count so that they
         // always agree with usedw.
         usedw        <= count_next;
         wrt_full     <= (count_next == DEPTH_C);
         rd_empty     <= (count_next == '0);
         almost_full  <= (count_next >= AF_C);
         almost_empty <= (count_next <= AE_C);
         if (wrt_en && wrt_full) overflow  <= 1'b1;
         if (rd_en && rd_empty)  underflow <= 1'b1;
      end
   end

   generate
      if (SHOWAHEAD) begin : g_showahead
         // The head word is presented directly. It is forced to zero while
         // empty so the output is clean after reset.
         assign data_out = rd_empty ? '0 : mem[rd_ptr];
      end else begin : g_normal
         // Registered read: the word appears one cycle after an accepted rd_en
         // and is held otherwise, including on an ignored read while empty.
         always_ff @(posedge clk) begin
            if (reset)
               data_out <= '0;
            else if (rd_ok)
               data_out <= mem[rd_ptr];
         end
      end
   endgenerate

endmodule
